// File: rtl/tristate_bus_arbiter_if.sv
// Request/enable bundle between bus requesters and the tristate bus arbiter.
// slave = arbiter side, master = requester side.
interface tristate_bus_arbiter_if #(
  parameter int NUM_DRIVERS = 4
) ();
  localparam int ID_W = (NUM_DRIVERS > 1) ? $clog2(NUM_DRIVERS) : 1;

  logic [NUM_DRIVERS-1:0] req;
  logic [NUM_DRIVERS-1:0] data_enable_low;
  logic                   grant_valid;
  logic [ID_W-1:0]        grant_id;
  logic                   bus_turnaround;

  modport master (
    output req,
    input  data_enable_low,
    input  grant_valid,
    input  grant_id,
    input  bus_turnaround
  );

  modport slave (
    input  req,
    output data_enable_low,
    output grant_valid,
    output grant_id,
    output bus_turnaround
  );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner select for a shared tristate bus with forced turnaround and bounded tenure.
// Latency: enable drops on the edge the request is sampled; requesters wait by holding req high.
module tristate_bus_arbiter #(
  parameter int NUM_DRIVERS       = 4,
  parameter int TURNAROUND_CYCLES = 1,
  parameter int MAX_HOLD          = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  tristate_bus_arbiter_if.slave  bus
);
  localparam int ID_W   = (NUM_DRIVERS > 1) ? $clog2(NUM_DRIVERS) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int TURN_W = $clog2(TURNAROUND_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_DRIVERS-1:0] en_q, en_d;
  logic                   gv_q, gv_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic                   ta_q, ta_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [TURN_W-1:0]      turn_q, turn_d;

  logic                   win_vld;
  logic [ID_W-1:0]        win_id;
  logic [ID_W-1:0]        idx;
  logic                   do_grant;

  // Search starts just past the previous owner so every requester gets a turn.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_DRIVERS; k++) begin
      idx = ID_W'((int'(last_q) + k) % NUM_DRIVERS);
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    gv_d     = gv_q;
    id_d     = id_q;
    ta_d     = ta_q;
    last_d   = last_q;
    hold_d   = hold_q;
    turn_d   = turn_q;
    do_grant = 1'b0;

    case (state_q)
      IDLE: begin
        do_grant = win_vld;
      end
      OWN: begin
        if (!bus.req[id_q] || hold_q == HOLD_W'(MAX_HOLD)) begin
          state_d = TURN;
          en_d    = '1;
          gv_d    = 1'b0;
          ta_d    = 1'b1;
          turn_d  = TURN_W'(1);
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      TURN: begin
        if (turn_q < TURN_W'(TURNAROUND_CYCLES)) begin
          turn_d = turn_q + TURN_W'(1);
        end else begin
          ta_d = 1'b0;
          if (win_vld) begin
            do_grant = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = '1;
        gv_d    = 1'b0;
        ta_d    = 1'b0;
      end
    endcase

    // Grants out of TURN go straight to the new owner; the bus was already released.
    if (do_grant) begin
      state_d = OWN;
      en_d    = {NUM_DRIVERS{1'b1}} ^ (NUM_DRIVERS'(1) << win_id);
      gv_d    = 1'b1;
      id_d    = win_id;
      hold_d  = HOLD_W'(1);
      last_d  = win_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= '1;
      gv_q    <= 1'b0;
      id_q    <= '0;
      ta_q    <= 1'b0;
      last_q  <= ID_W'(NUM_DRIVERS - 1);
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      gv_q    <= gv_d;
      id_q    <= id_d;
      ta_q    <= ta_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  assign bus.data_enable_low = en_q;
  assign bus.grant_valid     = gv_q;
  assign bus.grant_id        = id_q;
  assign bus.bus_turnaround  = ta_q;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Self-checking bench for tristate_bus_arbiter (N=4, TURNAROUND_CYCLES=1, MAX_HOLD=4).
module tb_tristate_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tristate_bus_arbiter_if #(.NUM_DRIVERS(4)) bus_if ();

  tristate_bus_arbiter #(
    .NUM_DRIVERS      (4),
    .TURNAROUND_CYCLES(1),
    .MAX_HOLD         (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] en;
    logic       gv;
    logic [1:0] id;
    logic       ta;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   total  = 0;
  int   bad    = 0;
  bit   inv_on = 1'b0;

  function automatic vec_t mk(logic [3:0] r, logic [3:0] e, logic g, int o, logic t);
    vec_t v;
    v.req = r; v.en = e; v.gv = g; v.id = 2'(o); v.ta = t;
    return v;
  endfunction

  function automatic logic [3:0] own_en(int o);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << o);
  endfunction

  function automatic void add_own(logic [3:0] r, int o);
    vecs.push_back(mk(r, own_en(o), 1'b1, o, 1'b0));
  endfunction

  function automatic void add_turn(logic [3:0] r, int o);
    vecs.push_back(mk(r, 4'b1111, 1'b0, o, 1'b1));
  endfunction

  function automatic void add_idle(logic [3:0] r, int o);
    vecs.push_back(mk(r, 4'b1111, 1'b0, o, 1'b0));
  endfunction

  task automatic check_now(input string name, input int n, input vec_t e);
    total++;
    if (bus_if.data_enable_low !== e.en || bus_if.grant_valid !== e.gv ||
        bus_if.grant_id !== e.id || bus_if.bus_turnaround !== e.ta) begin
      bad++;
      $display("FAIL %s #%0d: got en=%b gv=%b id=%0d ta=%b, want en=%b gv=%b id=%0d ta=%b",
               name, n, bus_if.data_enable_low, bus_if.grant_valid, bus_if.grant_id,
               bus_if.bus_turnaround, e.en, e.gv, e.id, e.ta);
    end
  endtask

  task automatic step(input string name, input int n, input vec_t v);
    vec_t e;
    bus_if.req = v.req;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_now(name, n, e);
  endtask

  // Never two drivers enabled, and grant_valid tracks "some enable low".
  always @(negedge clk) begin
    if (inv_on && !rst) begin
      total++;
      if (($countones(~bus_if.data_enable_low) > 1) ||
          ((bus_if.data_enable_low != 4'b1111) != bus_if.grant_valid)) begin
        bad++;
        $display("FAIL invariant: en=%b gv=%b", bus_if.data_enable_low, bus_if.grant_valid);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit=100000");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int   owners[5];
    owners = '{0, 1, 2, 3, 0};

    // Full contention from reset: 0,1,2,3,0 each for 4 cycles with 1 turnaround between.
    for (int j = 0; j < 5; j++) begin
      for (int c = 0; c < 4; c++) add_own(4'b1111, owners[j]);
      if (j < 4) add_turn(4'b1111, owners[j]);
    end
    add_turn(4'b0000, 0);
    add_idle(4'b0000, 0);
    // Single request from driver 2, dropped on the 4th edge.
    for (int c = 0; c < 3; c++) add_own(4'b0100, 2);
    add_turn(4'b0000, 2);
    add_idle(4'b0000, 2);
    add_idle(4'b0000, 2);
    // Lone hog on driver 1, held 12 cycles.
    for (int c = 0; c < 4; c++) add_own(4'b0010, 1);
    add_turn(4'b0010, 1);
    for (int c = 0; c < 4; c++) add_own(4'b0010, 1);
    add_turn(4'b0010, 1);
    add_own(4'b0010, 1);
    add_own(4'b0010, 1);
    add_turn(4'b0000, 1);
    add_idle(4'b0000, 1);
    // Coincident release: driver 2 drops req as tenure expires; driver 3 waits without preempting.
    for (int c = 0; c < 4; c++) add_own(4'b1100, 2);
    add_turn(4'b1000, 2);
    add_own(4'b1000, 3);
    add_turn(4'b0000, 3);
    add_idle(4'b0000, 3);

    // Reset asserted with every driver requesting; outputs must clear without an edge.
    bus_if.req = 4'b1111;
    #1 rst = 1'b1;
    #1;
    rv = mk(4'b1111, 4'b1111, 1'b0, 0, 1'b0);
    check_now("reset_async", 0, rv);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check_now("reset_hold", c, rv);
    end
    rst = 1'b0;
    inv_on = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step("vec", i, vecs[i]);

    // Asynchronous reset while driver 0 owns the bus.
    step("own0", 0, mk(4'b0001, 4'b1110, 1'b1, 0, 1'b0));
    step("own0", 1, mk(4'b0001, 4'b1110, 1'b1, 0, 1'b0));
    #2 rst = 1'b1;
    #1;
    check_now("reset_mid_own", 0, mk(4'b0001, 4'b1111, 1'b0, 0, 1'b0));
    #3 rst = 1'b0;
    bus_if.req = 4'b0000;
    @(posedge clk);
    #1;
    check_now("post_reset_idle", 0, mk(4'b0000, 4'b1111, 1'b0, 0, 1'b0));
    step("post_reset_rr", 0, mk(4'b1010, 4'b1101, 1'b1, 1, 1'b0));
    step("post_reset_rr", 1, mk(4'b1000, 4'b1111, 1'b0, 1, 1'b1));
    step("post_reset_rr", 2, mk(4'b1000, 4'b0111, 1'b1, 3, 1'b0));
    step("post_reset_rr", 3, mk(4'b0000, 4'b1111, 1'b0, 3, 1'b1));
    step("post_reset_rr", 4, mk(4'b0000, 4'b1111, 1'b0, 3, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Upstream control stage for a shared tristate data bus. It generates the active-low output enables for NUM_DRIVERS bufif0-style drivers.
- Round-robin arbitration among requesters; at most one enable low at any time.
- Forced turnaround (all drivers released) between owners so two drivers never fight on the bus.
- Bounded bus tenure (MAX_HOLD) prevents one requester starving the others.

Parameters:
- NUM_DRIVERS, 4, number of requesters/drivers on the bus (>=2).
- TURNAROUND_CYCLES, 1, idle cycles with all enables high between owners (>=1).
- MAX_HOLD, 8, max consecutive cycles one owner keeps the bus (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_DRIVERS  per-driver bus request, level, held while bus wanted.
- data_enable_low  output  NUM_DRIVERS  active-low driver enables; bit i low = driver i owns bus.
- grant_valid  output  1  high while some driver's enable is low.
- grant_id  output  max(1,$clog2(NUM_DRIVERS))  index of current owner; holds last owner when grant_valid=0.
- bus_turnaround  output  1  high during turnaround cycles.

Behaviour:
- All outputs registered. Clock is clk; reset is asynchronous, active-high; it takes effect immediately, not at the next edge.
- Reset values:
  - data_enable_low = all 1s.
  - grant_valid = 0, bus_turnaround = 0, grant_id = 0.
  - state = IDLE.
  - Internal last_owner = NUM_DRIVERS-1, so driver 0 has top priority after reset.
- Round-robin pick: first set bit of req searching (last_owner+1) mod N upward, wrapping.
- Invariant: data_enable_low has at most one 0 bit. data_enable_low ≠ all 1s ⇔ grant_valid=1.
- States:
  - IDLE:
    - At an edge with any req bit set: go to OWN.
    - Winner w: data_enable_low[w] <= 0, grant_id <= w, grant_valid <= 1, hold_cnt <= 1, last_owner <= w.
    - Latency from req seen at edge to enable low: that same edge (one registered stage).
  - OWN:
    - At each edge, release if req[owner]==0 OR hold_cnt==MAX_HOLD.
    - Release actions: enables <= all 1s, grant_valid <= 0, bus_turnaround <= 1, turn_cnt <= 1, go to TURN.
    - Otherwise hold_cnt increments. Owner holds the bus for at most MAX_HOLD cycles.
    - Requests from other drivers during OWN never preempt the owner.
  - TURN:
    - Enables all 1s.
    - If turn_cnt < TURNAROUND_CYCLES: turn_cnt increments.
    - At the edge where turn_cnt==TURNAROUND_CYCLES: bus_turnaround <= 0.
      - If any req is set: grant directly to the round-robin winner (go to OWN, same actions as IDLE).
      - Else go to IDLE.
    - No turnaround is inserted out of IDLE.
- Boundary conditions:
  - Owner still requesting at MAX_HOLD: released anyway. If it is the only requester, it is re-granted after turnaround.
  - req drop and MAX_HOLD on the same edge: a single release; no difference in timing.
  - All req low in TURN: go to IDLE.
  - req pulses that start and end within TURN: ignored (only sampled at the decision edge).
  - Reset mid-OWN: enables all 1s immediately (asynchronously); last_owner returns to N-1.
  - Counters sized to hold MAX_HOLD and TURNAROUND_CYCLES without wrap.

Test Plan:
- Params N=4, TURNAROUND_CYCLES=1, MAX_HOLD=4 throughout.
- Reset: assert rst with req=4'b1111 → data_enable_low=4'b1111, grant_valid=0, bus_turnaround=0 throughout, with no clock edge needed.
- Single request: req=4'b0100 seen at edge E, dropped before edge E+3 → enable=4'b1011 and grant_id=2 from E through E+2. Enable=4'b1111 with bus_turnaround=1 for one cycle after E+3, then IDLE.
- Full contention: req=4'b1111 held → owners 0,1,2,3,0 in order. Each owner has 4 cycles of enable low, separated by exactly 1 cycle of 4'b1111. A checker asserts popcount(~data_enable_low) ≤ 1 every cycle.
- Lone hog: only req[1]=1, held 12 cycles → enable 4'b1101 for 4 cycles, 1 turnaround cycle, then repeats. Owner is always 1.
- Coincident release: owner drops req on the same edge hold_cnt hits 4 → exactly one turnaround cycle. The next requester (req[3]) is granted at the following edge with enable=4'b0111.
- Async reset mid-OWN: rst pulsed between edges while enable=4'b1110 → enable=4'b1111 before the next edge. After release, req=4'b1010 grants driver 1 first.
